// File: rtl/sccb_target.sv
// SCCB (3-wire camera control bus) target: decodes 3-phase writes and 2-phase reads
// against an external register file, with an open-drain SIOD pull-down enable.
module sccb_target #(
    parameter logic [7:0] DEVICE_ID = 8'h42,
    parameter int         CLK_FREQ  = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    // CLK_FREQ carries no logic; it documents the clock this instance was sized for.
    if (CLK_FREQ < 1) begin : g_clk_freq_invalid
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_NA,
        S_IGNORE
    } state_e;

    localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

    logic       sioc_meta_q, sioc_sync_q, sioc_prev_q;
    logic       siod_meta_q, siod_sync_q, siod_prev_q;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rd_mode_q, rd_mode_d;
    logic       siod_oe_q, siod_oe_d;
    logic       reg_wr_en_q, reg_wr_en_d;
    logic [7:0] reg_wr_addr_q, reg_wr_addr_d;
    logic [7:0] reg_wr_data_q, reg_wr_data_d;
    logic [7:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;

    logic       sioc_rise, sioc_fall, start_det, stop_det;
    logic [7:0] byte_in;

    // Two-flop synchronisers plus one history flop for edge detection; idle bus level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_meta_q <= 1'b1;
            sioc_sync_q <= 1'b1;
            sioc_prev_q <= 1'b1;
            siod_meta_q <= 1'b1;
            siod_sync_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_meta_q <= sioc;
            sioc_sync_q <= sioc_meta_q;
            sioc_prev_q <= sioc_sync_q;
            siod_meta_q <= siod_in;
            siod_sync_q <= siod_meta_q;
            siod_prev_q <= siod_sync_q;
        end
    end

    assign sioc_rise = sioc_sync_q & ~sioc_prev_q;
    assign sioc_fall = ~sioc_sync_q & sioc_prev_q;
    assign start_det = sioc_sync_q & siod_prev_q & ~siod_sync_q;
    assign stop_det  = sioc_sync_q & ~siod_prev_q & siod_sync_q;
    assign byte_in   = {shift_q[6:0], siod_sync_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            rd_mode_q     <= 1'b0;
            siod_oe_q     <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= 8'h00;
            reg_wr_data_q <= 8'h00;
            ptr_q         <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rd_mode_q     <= rd_mode_d;
            siod_oe_q     <= siod_oe_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rd_mode_d     = rd_mode_q;
        siod_oe_d     = siod_oe_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        ptr_d         = ptr_q;

        if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            siod_oe_d = 1'b0;
        end else if (start_det) begin
            state_d   = S_ID;
            bit_cnt_d = 4'd0;
            siod_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ID: begin
                    if (sioc_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (byte_in == DEVICE_ID) begin
                                rd_mode_d = 1'b0;
                                state_d   = S_ID_ACK;
                            end else if (byte_in == READ_ID) begin
                                rd_mode_d = 1'b1;
                                state_d   = S_ID_ACK;
                            end else begin
                                state_d   = S_IGNORE;
                            end
                        end
                    end
                end
                S_SUB: begin
                    if (sioc_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            ptr_d     = byte_in;
                            state_d   = S_SUB_ACK;
                        end
                    end
                end
                S_WDATA: begin
                    if (sioc_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d     = 4'd0;
                            reg_wr_en_d   = 1'b1;
                            reg_wr_addr_d = ptr_q;
                            reg_wr_data_d = byte_in;
                            state_d       = S_WDATA_ACK;
                        end
                    end
                end
                // The first falling edge starts the ACK pull-down, the second ends it.
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (sioc_fall) begin
                        if (!siod_oe_q) begin
                            siod_oe_d = 1'b1;
                        end else begin
                            siod_oe_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == S_ID_ACK && rd_mode_q) begin
                                shift_d   = reg_rd_data;
                                siod_oe_d = ~reg_rd_data[7];
                                state_d   = S_RDATA;
                            end else if (state_q == S_ID_ACK) begin
                                state_d = S_SUB;
                            end else if (state_q == S_SUB_ACK) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                // bit_cnt counts master sample edges; after the eighth the line is released.
                S_RDATA: begin
                    if (sioc_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (sioc_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            siod_oe_d = 1'b0;
                            state_d   = S_RDATA_NA;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            siod_oe_d = ~shift_q[6];
                        end
                    end
                end
                S_RDATA_NA: begin
                    siod_oe_d = 1'b0;
                    if (sioc_rise) begin
                        state_d = S_IGNORE;
                    end
                end
                S_IGNORE: begin
                    siod_oe_d = 1'b0;
                end
                default: begin
                    siod_oe_d = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign siod_oe     = siod_oe_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_rd_addr = ptr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: an SCCB master drives directed and random transactions and
// compares acknowledges, read data, write strobes and status against a register-level model.
module tb_sccb_target;
  localparam int Q = 8;  // clk cycles per quarter SIOC period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sioc = 1'b1;
  logic       siod_m = 1'b1;
  logic       siod_in;
  logic       siod_oe;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  logic       busy;

  logic [7:0] regfile [256];
  bit         rf_init = 1'b0;
  logic [15:0] got_q[$];
  int         oe_cnt = 0;

  // model state
  logic [7:0]  exp_mem [256];
  logic [7:0]  ptr_m;
  logic [15:0] exp_q[$];
  int          got_idx = 0;

  int n_cmp = 0;
  int n_bad = 0;

  sccb_target #(.DEVICE_ID(8'h42), .CLK_FREQ(25000000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sioc(sioc),
    .siod_in(siod_in),
    .siod_oe(siod_oe),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .busy(busy)
  );

  // ---------------- clock / bus / register file ----------------
  always #5 clk = ~clk;

  assign siod_in = siod_m & ~siod_oe;
  assign reg_rd_data = regfile[reg_rd_addr];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h0A) return 8'h76;
    return (a * 8'd37) + 8'd11;
  endfunction

  always @(negedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 256; i++) regfile[i] = init_val(i[7:0]);
      rf_init = 1'b1;
    end
    if (reg_wr_en) begin
      got_q.push_back({reg_wr_addr, reg_wr_data});
      regfile[reg_wr_addr] = reg_wr_data;
    end
    if (siod_oe) oe_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, " wr_count"}, got_q.size() - got_idx, exp_q.size());
    while (exp_q.size() > 0 && got_idx < got_q.size()) begin
      check_eq({tag, " wr_addr_data"}, got_q[got_idx], exp_q.pop_front());
      got_idx++;
    end
    exp_q.delete();
    got_idx = got_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    siod_m = 1'b1; wait_q();
    sioc = 1'b1;   wait_q();
    siod_m = 1'b0; wait_q();
    sioc = 1'b0;   wait_q();
  endtask

  task automatic bus_stop();
    siod_m = 1'b0; wait_q();
    sioc = 1'b1;   wait_q();
    siod_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b, output logic seen);
    siod_m = b; wait_q();
    sioc = 1'b1; wait_q();
    seen = siod_in;
    wait_q();
    sioc = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_seen);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack_seen);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic na_seen);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(1'b1, na_seen);
  endtask

  // ---------------- transactions + model ----------------
  task automatic do_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data,
                          input int data_bits, input string tag);
    logic a;
    int   oe0;
    bit   valid;
    valid = (id == 8'h42);
    oe0 = oe_cnt;
    bus_start();
    check_eq({tag, " busy_start"}, busy, 1);
    send_byte(id, a);
    check_eq({tag, " id_ack"}, a, valid ? 32'd0 : 32'd1);
    send_byte(sub, a);
    check_eq({tag, " sub_ack"}, a, valid ? 32'd0 : 32'd1);
    if (valid) ptr_m = sub;
    if (data_bits == 8) begin
      send_byte(data, a);
      check_eq({tag, " data_ack"}, a, valid ? 32'd0 : 32'd1);
      if (valid) begin
        exp_q.push_back({ptr_m, data});
        exp_mem[ptr_m] = data;
      end
    end else begin
      for (int i = 0; i < data_bits; i++) send_bit(data[7 - i], a);
    end
    bus_stop();
    check_eq({tag, " busy_stop"}, busy, 0);
    check_eq({tag, " rd_addr"}, reg_rd_addr, ptr_m);
    if (!valid) check_eq({tag, " oe_silent"}, oe_cnt - oe0, 0);
    check_writes(tag);
  endtask

  task automatic read_phase(input string tag);
    logic       a, na;
    logic [7:0] b;
    send_byte(8'h43, a);
    check_eq({tag, " rid_ack"}, a, 0);
    recv_byte(b, na);
    check_eq({tag, " rdata"}, b, exp_mem[ptr_m]);
    check_eq({tag, " na_released"}, na, 1);
    bus_stop();
    check_eq({tag, " busy_stop"}, busy, 0);
    check_eq({tag, " rd_addr"}, reg_rd_addr, ptr_m);
    check_writes(tag);
  endtask

  task automatic do_read(input string tag);
    bus_start();
    check_eq({tag, " busy_start"}, busy, 1);
    read_phase(tag);
  endtask

  task automatic do_restart_read(input logic [7:0] sub, input string tag);
    logic a;
    bus_start();
    send_byte(8'h42, a);
    check_eq({tag, " id_ack"}, a, 0);
    send_byte(sub, a);
    check_eq({tag, " sub_ack"}, a, 0);
    ptr_m = sub;
    bus_start();
    check_eq({tag, " busy_rstart"}, busy, 1);
    read_phase(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " siod_oe"}, siod_oe, 0);
    check_eq({tag, " wr_en"}, reg_wr_en, 0);
    check_eq({tag, " busy"}, busy, 0);
    check_eq({tag, " wr_addr"}, reg_wr_addr, 0);
    check_eq({tag, " wr_data"}, reg_wr_data, 0);
    check_eq({tag, " rd_addr"}, reg_rd_addr, 0);
  endtask

  task automatic reset_mid_write();
    logic a;
    logic [7:0] data;
    data = 8'hC5;
    bus_start();
    send_byte(8'h42, a);
    check_eq("rst_mid id_ack", a, 0);
    send_byte(8'h33, a);
    check_eq("rst_mid sub_ack", a, 0);
    for (int i = 0; i < 4; i++) send_bit(data[7 - i], a);
    siod_m = data[3]; wait_q();
    sioc = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    ptr_m = 8'h00;
    wait_q();
    siod_m = 1'b1;
    wait_q();
    rst_n = 1'b1;
    wait_q(); wait_q();
    check_eq("rst_mid busy_after", busy, 0);
    check_writes("rst_mid");
  endtask

  // ---------------- main ----------------
  initial begin
    logic [7:0] id;
    int kind;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i[7:0]);
    ptr_m = 8'h00;

    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    wait_q();

    do_write(8'h42, 8'h12, 8'h80, 8, "w3_12_80");
    do_write(8'h42, 8'h0A, 8'h00, 0, "w2_0A");
    do_read("rd_0A");
    do_write(8'h60, 8'h12, 8'h34, 8, "bad_id_60");
    do_write(8'h42, 8'h12, 8'hAB, 4, "partial");
    do_write(8'h42, 8'h15, 8'h01, 8, "after_partial");
    reset_mid_write();
    do_write(8'h42, 8'h3A, 8'h04, 8, "after_rst");
    do_restart_read(8'h0A, "rstart_0A");

    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: do_write(8'h42, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8, "rnd_w3");
        1: do_read("rnd_rd");
        2: do_write(8'h42, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    $urandom_range(1, 6), "rnd_partial");
        3: begin
          do id = 8'($urandom_range(0, 255)); while (id == 8'h42 || id == 8'h43);
          do_write(id, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8, "rnd_bad_id");
        end
        4: do_restart_read(8'($urandom_range(0, 255)), "rnd_rstart");
        default: do_write(8'h42, 8'($urandom_range(0, 255)), 8'h00, 0, "rnd_w2");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
